// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the multiply/divide FSM state type.
// No ports: imported by muldiv_unit and its testbench.
package riscv_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b011_0011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, single-cycle result pulse.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_valid, i_funct3     request strobe and operation select (accepted when o_ready)
//   i_rs1, i_rs2          operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   i_kill                flush; abandons any operation in flight
//   o_ready, o_busy       idle / operation in progress
//   o_valid, o_result     one-cycle result strobe and result word
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned DW = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]   r_acc;       // shared shift register: {hi, lo}
  logic [XLEN-1:0] r_b;         // multiplicand or divisor
  logic [2:0]      r_f3;
  logic            r_neg;
  logic [XLEN-1:0] r_result;
  logic            r_ready, r_busy, r_valid;

  logic            w_accept, w_special, w_div_zero, w_overflow;
  logic            w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;
  logic            w_ready_nxt, w_busy_nxt, w_valid_nxt;

  // Operand sign handling and special-case detection at accept
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    w_neg = 1'b0;
    case (i_funct3)
      F3_MULH, F3_DIV: begin
        w_sa = 1'b1;
        w_sb = 1'b1;
        w_neg = i_rs1[XLEN-1] ^ i_rs2[XLEN-1];
      end
      F3_MULHSU: begin
        w_sa = 1'b1;
        w_neg = i_rs1[XLEN-1];
      end
      F3_REM: begin
        w_sa = 1'b1;
        w_sb = 1'b1;
        w_neg = i_rs1[XLEN-1];
      end
      default: ;
    endcase
    w_a_mag = (w_sa && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
    w_b_mag = (w_sb && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
    w_div_zero = i_funct3[2] && (i_rs2 == '0);
    w_overflow = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                 (i_rs1 == INT_MIN) && (i_rs2 == '1);
    w_special = w_div_zero || w_overflow;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (w_div_zero) w_special_res = i_funct3[1] ? i_rs1 : '1;
    else            w_special_res = i_funct3[1] ? '0 : INT_MIN;
  end

  assign w_accept = (r_state == IDLE) && i_valid && !i_kill;

  // Multiply step: conditional add into hi, then shift the whole register right
  logic [XLEN:0]   w_add;
  logic [DW-1:0]   w_mul_step;
  assign w_add      = r_acc[0] ? ({1'b0, r_acc[DW-1:XLEN]} + {1'b0, r_b})
                               : {1'b0, r_acc[DW-1:XLEN]};
  assign w_mul_step = {w_add, r_acc[XLEN-1:1]};

  // Restoring divide step: {hi, next dividend bit} against the divisor
  logic [XLEN:0]   w_pr;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [DW-1:0]   w_div_step;
  assign w_pr       = r_acc[DW-1:XLEN-1];
  assign w_ge       = w_pr >= {1'b0, r_b};
  assign w_diff     = XLEN'(w_pr - {1'b0, r_b});
  assign w_div_step = {(w_ge ? w_diff : w_pr[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

  // Sign fix-up and result selection
  logic [DW-1:0]   w_prod;
  logic [XLEN-1:0] w_quo, w_rem, w_fix_res;
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? -r_acc[DW-1:XLEN] : r_acc[DW-1:XLEN];
  always_comb begin
    w_fix_res = w_prod[DW-1:XLEN];
    case (r_f3)
      F3_MUL:           w_fix_res = w_prod[XLEN-1:0];
      F3_DIV, F3_DIVU:  w_fix_res = w_quo;
      F3_REM, F3_REMU:  w_fix_res = w_rem;
      default:          w_fix_res = w_prod[DW-1:XLEN];
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and registered-output next values
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (r_cnt == CNT_LAST) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (i_kill) w_state_nxt = IDLE;
    w_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_valid_nxt = (w_state_nxt == DONE);
  end

  // Registered status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Iteration counter; wraps 31 -> 0 as CALC ends
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         r_cnt <= '0;
    else if (r_state == CALC && !i_kill)  r_cnt <= r_cnt + CNT_W'(1);
    else                                  r_cnt <= '0;
  end

  // Datapath: operand load, iteration, result capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_special) begin
            r_result <= w_special_res;
          end else begin
            r_f3  <= i_funct3;
            r_neg <= w_neg;
            r_b   <= i_funct3[2] ? w_b_mag : w_a_mag;
            r_acc <= {{XLEN{1'b0}}, (i_funct3[2] ? w_a_mag : w_b_mag)};
          end
        end
        CALC: if (!i_kill) r_acc <= r_f3[2] ? w_div_step : w_mul_step;
        FIX:  if (!i_kill) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: results, latency, kill, reset and back-to-back.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic        i_kill = 1'b0;
  logic        o_ready, o_busy, o_valid;
  logic [31:0] o_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .i_funct3 (i_funct3),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_kill   (i_kill),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request just after a falling edge; it is sampled at the next rising edge
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_valid  = 1'b1;
    i_funct3 = f3;
    i_rs1    = a;
    i_rs2    = b;
  endtask

  // Count falling edges until o_valid; lat=0 means it never came
  task automatic wait_valid(input logic hold, output int lat, output int busy_low);
    lat = 0;
    busy_low = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (!hold) i_valid = 1'b0;
      if (!o_busy) busy_low++;
      if (o_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, busy_low;
    start_op(f3, a, b);
    wait_valid(1'b0, lat, busy_low);
    check({tag, "/result"}, o_result, exp);
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/busy"}, busy_low, 0);
  endtask

  initial begin
    int lat, busy_low, vcount;

    repeat (2) @(negedge clk);
    check("reset/ready", o_ready, 1);
    check("reset/busy", o_busy, 0);
    check("reset/valid", o_valid, 0);
    check("reset/result", o_result, 0);
    rst_n = 1'b1;

    run_op("mul_7x-3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    @(negedge clk);
    check("mul/ready_after", o_ready, 1);
    check("mul/valid_pulse", o_valid, 0);
    check("mul/result_held", o_result, 32'hFFFF_FFEB);

    run_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhsu", F3_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34);
    run_op("mulhu", F3_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);

    run_op("div_-7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_-7/2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_100/7", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100/7", F3_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_7/-2", F3_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);

    run_op("divu_5/0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5/0", F3_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Kill ten cycles into a divide
    start_op(F3_DIV, 32'd1000, 32'd3);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    check("kill/ready", o_ready, 1);
    check("kill/busy", o_busy, 0);
    check("kill/valid", o_valid, 0);
    vcount = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_valid) vcount++;
    end
    check("kill/no_valid", vcount, 0);
    run_op("mul_3x4", F3_MUL, 32'd3, 32'd4, 32'd12, 34);

    // Reset in the middle of CALC
    start_op(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid/busy", o_busy, 0);
    check("rst_mid/valid", o_valid, 0);
    check("rst_mid/result", o_result, 0);
    check("rst_mid/ready", o_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back with i_valid held high
    start_op(F3_DIVU, 32'd100, 32'd7);
    wait_valid(1'b1, lat, busy_low);
    check("b2b/first_result", o_result, 32'd14);
    check("b2b/first_latency", lat, 34);
    @(negedge clk);
    check("b2b/idle_ready", o_ready, 1);
    check("b2b/idle_busy", o_busy, 0);
    @(negedge clk);
    check("b2b/second_accepted", o_busy, 1);
    check("b2b/second_not_ready", o_ready, 0);
    i_valid = 1'b0;
    // Second request was sampled one edge before this point
    wait_valid(1'b0, lat, busy_low);
    check("b2b/second_result", o_result, 32'd14);
    check("b2b/second_latency", lat, 33);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
